// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the execute-stage datapath.
//   - DW_DEFAULT / RW_DEFAULT : default datapath and register-index widths
//   - ALU_* : ALU operation encodings carried on ALU_sel
//   - fwd_sel_e : operand forwarding source select
package mips_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned RW_DEFAULT = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU, shared with the branch-compare unit.
// Ports:
//   i_a, i_b   : DW-bit operands
//   i_alu_sel  : operation (mips_pkg::ALU_*); unknown codes give 0
//   o_result   : DW-bit result, wrap-around arithmetic
//   o_zero     : 1 when o_result is all zeros
module alu
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_alu_sel,
  output logic [DW-1:0] o_result,
  output logic          o_zero
);

  logic w_slt;

  assign w_slt = ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_result = '0;
    case (i_alu_sel)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(DW-1){1'b0}}, w_slt};
      ALU_NOR: o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus the execute/memory pipeline register.
// Ports:
//   CLK, CLR            : clock and asynchronous active-low reset
//   EN, FLUSH           : capture enable / bubble insert (FLUSH wins)
//   *_E                 : decode/execute bundle (control, operands, indices, imm, PC+4)
//   RsD, RtD            : decode-stage sources, for load-use detection
//   ResultW, WriteRegW, RFWE_W : writeback bus, used as a forwarding source
//   *_M                 : registered execute results for the memory stage
//   LoadUse             : combinational stall request to decode
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          EN,
  input  logic          FLUSH,
  input  logic          RFWE_E,
  input  logic          RFDSel_E,
  input  logic          ALU_In_sel_E,
  input  logic          branch_E,
  input  logic          DMWE_E,
  input  logic          MtoRFsel_E,
  input  logic          jump_E,
  input  logic [3:0]    ALU_sel_E,
  input  logic [DW-1:0] RFD1_E,
  input  logic [DW-1:0] RFD2_E,
  input  logic [RW-1:0] RsE,
  input  logic [RW-1:0] RtE,
  input  logic [RW-1:0] RdE,
  input  logic [DW-1:0] SIMM_E,
  input  logic [DW-1:0] PCPlus4_E,
  input  logic [RW-1:0] RsD,
  input  logic [RW-1:0] RtD,
  input  logic [DW-1:0] ResultW,
  input  logic [RW-1:0] WriteRegW,
  input  logic          RFWE_W,
  output logic          RFWE_M,
  output logic          MtoRFsel_M,
  output logic          DMWE_M,
  output logic [DW-1:0] ALUOut_M,
  output logic [DW-1:0] WriteData_M,
  output logic [DW-1:0] PCBranch_M,
  output logic [RW-1:0] WriteReg_M,
  output logic          PCSrc_M,
  output logic          Jump_M,
  output logic          LoadUse
);

  logic          r_rfwe;
  logic          r_mtorf;
  logic          r_dmwe;
  logic [DW-1:0] r_alu_out;
  logic [DW-1:0] r_write_data;
  logic [DW-1:0] r_pc_branch;
  logic [RW-1:0] r_write_reg;
  logic          r_pc_src;
  logic          r_jump;

  logic [RW-1:0] w_write_reg_e;
  fwd_sel_e      w_fwd_a_sel;
  fwd_sel_e      w_fwd_b_sel;
  logic [DW-1:0] w_src_a;
  logic [DW-1:0] w_fwd_b;
  logic [DW-1:0] w_src_b;
  logic [DW-1:0] w_alu_result;
  logic          w_alu_zero;
  logic [DW-1:0] w_pc_branch;

  assign w_write_reg_e = RFDSel_E ? RdE : RtE;

  // A load in MEM has no data yet (ALUOut_M is its address), so it is excluded
  // from MEM forwarding; the LoadUse stall guarantees it reaches WB first.
  always_comb begin
    w_fwd_a_sel = FWD_RF;
    if (r_rfwe && !r_mtorf && (r_write_reg != '0) && (r_write_reg == RsE)) begin
      w_fwd_a_sel = FWD_MEM;
    end else if (RFWE_W && (WriteRegW != '0) && (WriteRegW == RsE)) begin
      w_fwd_a_sel = FWD_WB;
    end

    w_fwd_b_sel = FWD_RF;
    if (r_rfwe && !r_mtorf && (r_write_reg != '0) && (r_write_reg == RtE)) begin
      w_fwd_b_sel = FWD_MEM;
    end else if (RFWE_W && (WriteRegW != '0) && (WriteRegW == RtE)) begin
      w_fwd_b_sel = FWD_WB;
    end
  end

  always_comb begin
    w_src_a = RFD1_E;
    case (w_fwd_a_sel)
      FWD_MEM: w_src_a = r_alu_out;
      FWD_WB:  w_src_a = ResultW;
      default: w_src_a = RFD1_E;
    endcase

    w_fwd_b = RFD2_E;
    case (w_fwd_b_sel)
      FWD_MEM: w_fwd_b = r_alu_out;
      FWD_WB:  w_fwd_b = ResultW;
      default: w_fwd_b = RFD2_E;
    endcase
  end

  assign w_src_b     = ALU_In_sel_E ? SIMM_E : w_fwd_b;
  assign w_pc_branch = PCPlus4_E + (SIMM_E << 2);

  alu #(
    .DW(DW)
  ) u_alu (
    .i_a      (w_src_a),
    .i_b      (w_src_b),
    .i_alu_sel(ALU_sel_E),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  // FLUSH overrides a hold so a bubble can be inserted while the stage stalls.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_rfwe       <= 1'b0;
      r_mtorf      <= 1'b0;
      r_dmwe       <= 1'b0;
      r_alu_out    <= '0;
      r_write_data <= '0;
      r_pc_branch  <= '0;
      r_write_reg  <= '0;
      r_pc_src     <= 1'b0;
      r_jump       <= 1'b0;
    end else if (FLUSH) begin
      r_rfwe       <= 1'b0;
      r_mtorf      <= 1'b0;
      r_dmwe       <= 1'b0;
      r_alu_out    <= '0;
      r_write_data <= '0;
      r_pc_branch  <= '0;
      r_write_reg  <= '0;
      r_pc_src     <= 1'b0;
      r_jump       <= 1'b0;
    end else if (EN) begin
      r_rfwe       <= RFWE_E;
      r_mtorf      <= MtoRFsel_E;
      r_dmwe       <= DMWE_E;
      r_alu_out    <= w_alu_result;
      r_write_data <= w_fwd_b;
      r_pc_branch  <= w_pc_branch;
      r_write_reg  <= w_write_reg_e;
      r_pc_src     <= branch_E & w_alu_zero;
      r_jump       <= jump_E;
    end
  end

  assign RFWE_M      = r_rfwe;
  assign MtoRFsel_M  = r_mtorf;
  assign DMWE_M      = r_dmwe;
  assign ALUOut_M    = r_alu_out;
  assign WriteData_M = r_write_data;
  assign PCBranch_M  = r_pc_branch;
  assign WriteReg_M  = r_write_reg;
  assign PCSrc_M     = r_pc_src;
  assign Jump_M      = r_jump;

  assign LoadUse = MtoRFsel_E & RFWE_E & (w_write_reg_e != '0) &
                   ((w_write_reg_e == RsD) | (w_write_reg_e == RtD));

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors for ex_mem_stage. A behavioural model of the
// stage result runs alongside and is compared every negedge; literal values
// from hand calculation pin the model at key points.
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          CLK, CLR, EN, FLUSH;
  logic          RFWE_E, RFDSel_E, ALU_In_sel_E, branch_E, DMWE_E, MtoRFsel_E, jump_E;
  logic [3:0]    ALU_sel_E;
  logic [DW-1:0] RFD1_E, RFD2_E, SIMM_E, PCPlus4_E, ResultW;
  logic [RW-1:0] RsE, RtE, RdE, RsD, RtD, WriteRegW;
  logic          RFWE_W;
  logic          RFWE_M, MtoRFsel_M, DMWE_M, PCSrc_M, Jump_M, LoadUse;
  logic [DW-1:0] ALUOut_M, WriteData_M, PCBranch_M;
  logic [RW-1:0] WriteReg_M;

  int checks = 0;
  int failures = 0;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .FLUSH(FLUSH),
    .RFWE_E(RFWE_E), .RFDSel_E(RFDSel_E), .ALU_In_sel_E(ALU_In_sel_E),
    .branch_E(branch_E), .DMWE_E(DMWE_E), .MtoRFsel_E(MtoRFsel_E), .jump_E(jump_E),
    .ALU_sel_E(ALU_sel_E), .RFD1_E(RFD1_E), .RFD2_E(RFD2_E),
    .RsE(RsE), .RtE(RtE), .RdE(RdE), .SIMM_E(SIMM_E), .PCPlus4_E(PCPlus4_E),
    .RsD(RsD), .RtD(RtD), .ResultW(ResultW), .WriteRegW(WriteRegW), .RFWE_W(RFWE_W),
    .RFWE_M(RFWE_M), .MtoRFsel_M(MtoRFsel_M), .DMWE_M(DMWE_M),
    .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M), .PCBranch_M(PCBranch_M),
    .WriteReg_M(WriteReg_M), .PCSrc_M(PCSrc_M), .Jump_M(Jump_M), .LoadUse(LoadUse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_rfwe = 0, m_mtorf = 0, m_dmwe = 0, m_pcsrc = 0, m_jump = 0;
  logic [31:0] m_alu = 0, m_wd = 0, m_pcb = 0;
  logic [4:0]  m_wreg = 0;

  function automatic logic [31:0] alu_model(input logic [3:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    case (sel)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Value an operand must see: newest pending producer of that register wins.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (m_rfwe && !m_mtorf && m_wreg == idx) return m_alu;
    if (RFWE_W && WriteRegW == idx) return ResultW;
    return rf;
  endfunction

  function automatic logic [31:0] result_model();
    return alu_model(ALU_sel_E, operand(RsE, RFD1_E),
                     ALU_In_sel_E ? SIMM_E : operand(RtE, RFD2_E));
  endfunction

  function automatic logic loaduse_model();
    logic [4:0] dst;
    dst = RFDSel_E ? RdE : RtE;
    return MtoRFsel_E && RFWE_E && dst != 0 && (dst == RsD || dst == RtD);
  endfunction

  always @(posedge CLK or negedge CLR) begin
    if (!CLR || FLUSH) begin
      m_rfwe <= 0; m_mtorf <= 0; m_dmwe <= 0; m_pcsrc <= 0; m_jump <= 0;
      m_alu <= 0; m_wd <= 0; m_pcb <= 0; m_wreg <= 0;
    end else if (EN) begin
      m_rfwe  <= RFWE_E;
      m_mtorf <= MtoRFsel_E;
      m_dmwe  <= DMWE_E;
      m_jump  <= jump_E;
      m_alu   <= result_model();
      m_pcsrc <= branch_E && (result_model() == 0);
      m_wd    <= operand(RtE, RFD2_E);
      m_pcb   <= PCPlus4_E + SIMM_E * 4;
      m_wreg  <= RFDSel_E ? RdE : RtE;
    end
  end

  // Compare process: inputs only change at negedge+1, so here they are stable.
  always @(negedge CLK) begin
    chk("m_rfwe", RFWE_M, m_rfwe);
    chk("m_mtorf", MtoRFsel_M, m_mtorf);
    chk("m_dmwe", DMWE_M, m_dmwe);
    chk("m_aluout", ALUOut_M, m_alu);
    chk("m_wdata", WriteData_M, m_wd);
    chk("m_pcbranch", PCBranch_M, m_pcb);
    chk("m_wreg", WriteReg_M, m_wreg);
    chk("m_pcsrc", PCSrc_M, m_pcsrc);
    chk("m_jump", Jump_M, m_jump);
    chk("m_loaduse", LoadUse, loaduse_model());
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic ex(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                    input logic rfdsel, input logic rfwe);
    ALU_sel_E = sel; RFD1_E = a; RFD2_E = b; RsE = rs; RtE = rt; RdE = rd;
    RFDSel_E = rfdsel; RFWE_E = rfwe;
    ALU_In_sel_E = 0; branch_E = 0; DMWE_E = 0; MtoRFsel_E = 0; jump_E = 0;
    SIMM_E = 0; PCPlus4_E = 0;
  endtask

  initial begin
    CLR = 1; EN = 0; FLUSH = 0;
    ex(4'b0000, 0, 0, 0, 0, 0, 0, 0);
    RsD = 0; RtD = 0; ResultW = 0; WriteRegW = 0; RFWE_W = 0;
    #1 CLR = 0;
    tick();
    chk("reset_aluout", ALUOut_M, 32'd0);
    chk("reset_rfwe", RFWE_M, 32'd0);
    chk("reset_pcbranch", PCBranch_M, 32'd0);

    // ADD 5+7 -> r3
    CLR = 1; EN = 1;
    ex(4'b0010, 5, 7, 0, 0, 3, 1, 1);
    #1 chk("pre_edge_aluout", ALUOut_M, 32'd0);
    tick();
    chk("add_aluout", ALUOut_M, 32'd12);
    chk("add_wreg", WriteReg_M, 32'd3);
    chk("add_rfwe", RFWE_M, 32'd1);

    // MEM forward: r3(12) - 1
    ex(4'b0110, 0, 1, 3, 4, 5, 1, 1);
    tick();
    chk("mem_fwd", ALUOut_M, 32'd11);

    // r3 = 20 into MEM, then WB also offers r3 = 99: MEM wins
    ex(4'b0010, 20, 0, 0, 0, 3, 1, 1);
    tick();
    ex(4'b0001, 0, 0, 3, 0, 6, 1, 1);
    RFWE_W = 1; WriteRegW = 3; ResultW = 99;
    tick();
    chk("mem_over_wb", ALUOut_M, 32'd20);

    // WB-only forward: r7 = 99, + 1
    ex(4'b0010, 0, 1, 7, 0, 9, 1, 1);
    WriteRegW = 7;
    tick();
    chk("wb_fwd", ALUOut_M, 32'd100);
    RFWE_W = 0;

    // SLT signed: -1 < 1
    ex(4'b0111, 32'hFFFF_FFFF, 1, 0, 0, 10, 1, 1);
    tick();
    chk("slt_signed", ALUOut_M, 32'd1);

    ex(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 0, 0, 10, 1, 1);
    tick();
    chk("nor", ALUOut_M, 32'h0000_000F);

    // Store: 10 + imm(-2), WriteData is register B before the immediate mux
    ex(4'b0010, 10, 32'h55, 0, 0, 0, 0, 0);
    ALU_In_sel_E = 1; SIMM_E = 32'hFFFF_FFFE; DMWE_E = 1;
    tick();
    chk("imm_add", ALUOut_M, 32'd8);
    chk("store_wdata", WriteData_M, 32'h55);
    chk("store_dmwe", DMWE_M, 32'd1);

    // Taken branch with jump/store/write flags also set
    ex(4'b0110, 4, 4, 0, 0, 0, 0, 1);
    branch_E = 1; PCPlus4_E = 32'h100; SIMM_E = 32'hFFFF_FFFE; DMWE_E = 1; jump_E = 1;
    tick();
    chk("br_pcsrc", PCSrc_M, 32'd1);
    chk("br_target", PCBranch_M, 32'h0000_00F8);
    chk("br_jump", Jump_M, 32'd1);

    // Hold for 3 edges while inputs change
    EN = 0;
    ex(4'b0010, 1, 1, 0, 0, 2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pcsrc", PCSrc_M, 32'd1);
      chk("hold_target", PCBranch_M, 32'h0000_00F8);
    end

    // Flush while held
    FLUSH = 1;
    tick();
    chk("flush_rfwe", RFWE_M, 32'd0);
    chk("flush_dmwe", DMWE_M, 32'd0);
    chk("flush_pcsrc", PCSrc_M, 32'd0);
    chk("flush_jump", Jump_M, 32'd0);
    FLUSH = 0; EN = 1;

    // Untaken branch
    ex(4'b0110, 4, 3, 0, 0, 0, 0, 0);
    branch_E = 1; PCPlus4_E = 32'h100; SIMM_E = 32'd1;
    tick();
    chk("nbr_pcsrc", PCSrc_M, 32'd0);
    chk("nbr_target", PCBranch_M, 32'h0000_0104);

    // Load to r8 (base 0x40 + 4) with decode reading r8
    ex(4'b0010, 32'h40, 0, 0, 8, 0, 0, 1);
    MtoRFsel_E = 1; ALU_In_sel_E = 1; SIMM_E = 4; RsD = 8;
    #1 chk("loaduse_hit", LoadUse, 32'd1);
    RtE = 0;
    #1 chk("loaduse_r0", LoadUse, 32'd0);
    RtE = 8; RsD = 0; RtD = 8;
    #1 chk("loaduse_rt", LoadUse, 32'd1);
    tick();
    chk("load_addr", ALUOut_M, 32'h44);
    chk("load_mtorf", MtoRFsel_M, 32'd1);
    RtD = 0;

    // Load in MEM must not forward its address
    ex(4'b0010, 7, 0, 8, 0, 11, 1, 1);
    tick();
    chk("no_load_fwd", ALUOut_M, 32'd7);

    // Write to r0 is never forwarded
    ex(4'b0010, 50, 0, 0, 0, 0, 1, 1);
    tick();
    ex(4'b0010, 1, 0, 0, 0, 12, 1, 1);
    tick();
    chk("r0_no_fwd", ALUOut_M, 32'd1);

    // Asynchronous reset between edges
    ex(4'b0010, 3, 4, 0, 0, 13, 1, 1);
    tick();
    chk("pre_reset", ALUOut_M, 32'd7);
    CLR = 0;
    #1;
    chk("async_aluout", ALUOut_M, 32'd0);
    chk("async_wreg", WriteReg_M, 32'd0);
    chk("async_rfwe", RFWE_M, 32'd0);
    #1 CLR = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-stage consumer of the decode/execute pipeline-register bundle: control bits, register operands, register indices and sign-extended immediate.
- Performs MEM/WB operand forwarding and ALU evaluation.
- Resolves the write-register index and the branch target.
- Captures results into an execute/memory register with hold and bubble control.
- Flags load-use hazards back to the decode stage.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- CLK  input  1  single clock, all state on posedge.
- CLR  input  1  asynchronous, active-low reset.
- EN  input  1  1 = capture execute results; 0 = hold the execute/memory register.
- FLUSH  input  1  1 = load a bubble into the execute/memory register on the next edge.
- RFWE_E, RFDSel_E, ALU_In_sel_E, branch_E, DMWE_E, MtoRFsel_E, jump_E  input  1 each  execute-stage control bits.
- ALU_sel_E  input  4  ALU operation.
- RFD1_E, RFD2_E  input  DW  register-file operands.
- RsE, RtE, RdE  input  RW  register indices.
- SIMM_E  input  DW  sign-extended immediate.
- PCPlus4_E  input  DW  address of the next instruction.
- RsD, RtD  input  RW  source indices of the instruction in decode.
- ResultW  input  DW  writeback data.
- WriteRegW  input  RW  writeback index.
- RFWE_W  input  1  writeback enable.
- RFWE_M, MtoRFsel_M, DMWE_M  output  1 each  registered control bits.
- ALUOut_M, WriteData_M, PCBranch_M  output  DW  registered data.
- WriteReg_M  output  RW  registered destination index.
- PCSrc_M  output  1  registered branch-taken flag.
- Jump_M  output  1  registered jump flag.
- LoadUse  output  1  combinational stall request to decode.

Behaviour:
- Reset (CLR=0, asynchronous): every registered output is 0. The register holds a bubble.
- Latency: exactly one edge from the E-side inputs to the _M outputs.
- Destination index: WriteRegE = RFDSel_E ? RdE : RtE.
- Forward select for operand A (operand B identical using RtE):
  - Select MEM (ALUOut_M) if RFWE_M=1, MtoRFsel_M=0, WriteReg_M!=0 and WriteReg_M==RsE.
  - Else select WB (ResultW) if RFWE_W=1, WriteRegW!=0 and WriteRegW==RsE.
  - Else select RFD1_E.
  - MEM has priority over WB.
- SrcB = ALU_In_sel_E ? SIMM_E : forwarded B.
- WriteData = forwarded B, before the immediate mux.
- ALU_sel encodings, all DW-bit with wrap-around:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - SLT is a signed compare giving 0 or 1.
  - Any other code yields 0.
  - Zero = (result == 0).
- Branch target: PCBranch = PCPlus4_E + (SIMM_E << 2), truncated to DW.
- PCSrc_M: captures branch_E & Zero.
- Edge priority:
  - FLUSH=1: all control outputs, PCSrc_M and Jump_M go to 0. Data registers are don't-care, and the implementation zeroes them.
  - Else EN=0: all outputs hold.
  - Else: capture.
  - FLUSH overrides EN=0.
- LoadUse = MtoRFsel_E & RFWE_E & (WriteRegE!=0) & (WriteRegE==RsD | WriteRegE==RtD). Purely combinational; independent of EN and FLUSH.
- A load sitting in MEM is never forwarded from ALUOut_M. Decode must have stalled on LoadUse the previous cycle.
- Reset asserted mid-operation clears the register immediately, independent of CLK.
- Index 0 is never forwarded and never raises LoadUse.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_sel encoding constants.
  - Forward-select constants: FWD_RF=0, FWD_WB=1, FWD_MEM=2.
  - DW and RW defaults.
- Sub-module alu: combinational ALU taking a, b and ALU_sel, producing result and zero. It is reused later by the branch-compare unit.
- Forwarding muxes, branch adder and the execute/memory register stay in ex_mem_stage.

Test Plan:
- Reset then ADD:
  - Stimulus: release CLR; EN=1; ALU_sel=0010, RFD1_E=5, RFD2_E=7, ALU_In_sel=0, RFDSel=1, RdE=3, RFWE_E=1.
  - Response: after one edge ALUOut_M=12, WriteReg_M=3, RFWE_M=1. All outputs were 0 before the edge.
- MEM forward:
  - Stimulus: previous instruction writes r3=12; next has RsE=3, RFD1_E=0, RFD2_E=1, SUB.
  - Response: ALUOut_M=11.
- WB versus MEM priority:
  - Stimulus: same r3 is pending in both MEM (20) and WB (ResultW=99); RsE=3, OR with 0.
  - Response: ALUOut_M=20.
- Taken branch:
  - Stimulus: branch_E=1, SUB of 4-4, PCPlus4_E=0x100, SIMM_E=0xFFFFFFFE.
  - Response: PCSrc_M=1, PCBranch_M=0xF8.
- Load-use:
  - Stimulus: MtoRFsel_E=1, RFWE_E=1, RFDSel_E=0, RtE=8, RsD=8.
  - Response: LoadUse=1 in the same cycle. With RtE=0, LoadUse=0.
- Hold, flush, async reset:
  - EN=0 for 3 edges: outputs unchanged.
  - FLUSH=1 together with EN=0: RFWE_M=DMWE_M=PCSrc_M=0 after the edge.
  - CLR pulsed low between edges: outputs 0 immediately.
